// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of the fetch/decode register.
// Keeps the fetch PC and allows a single outstanding imem request.
// Buffers returned words in an output slot plus one skid entry.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned PCs are not fetched.
// Instead the slot presents a 32'h0000_0013 word flagged on fetch_o_misalign.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req_valid,
   output logic [63:0]  imem_req_addr,
   input  logic         imem_req_ready,
   input  logic         imem_resp_valid,
   input  logic [31:0]  imem_resp_data,
   input  logic         redirect_valid,
   input  logic [63:0]  redirect_pc,
   input  logic         fetch_stall,
   output logic         fetch_o_valid,
   output logic [63:0]  fetch_o_pc,
   output logic [31:0]  fetch_o_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic         fetch_o_misalign,
`endif
   output logic [160:0] fetch_o_commit_info
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_FULL = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [63:0] pc, pc_n;
   logic        slot_valid, slot_valid_n;
   logic [63:0] slot_pc, slot_pc_n;
   logic [31:0] slot_instr, slot_instr_n;
   logic        skid_valid, skid_valid_n;
   logic [63:0] skid_pc, skid_pc_n;
   logic [31:0] skid_instr, skid_instr_n;
   logic        handshake;
   logic [63:0] pc_plus4;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic        slot_misalign, slot_misalign_n;
   logic        misalign_done, misalign_done_n;
   logic        misaligned;

   assign misaligned       = (pc[1:0] != 2'b00);
   assign imem_req_valid   = rst && (state == ST_REQ) && !misaligned;
   assign imem_req_addr    = pc;
   assign fetch_o_misalign = slot_misalign;
`else
   assign imem_req_valid   = rst && (state == ST_REQ);
   assign imem_req_addr    = {pc[63:2], 2'b00};
`endif

   assign handshake = imem_req_valid && imem_req_ready;
   assign pc_plus4  = pc + 64'd4;

   assign fetch_o_valid       = slot_valid;
   assign fetch_o_pc          = slot_pc;
   assign fetch_o_instr       = slot_instr;
   assign fetch_o_commit_info = slot_valid ? {1'b1, slot_pc, slot_pc + 64'd4, slot_instr} : 161'd0;

   // Next-state and buffer update: redirect first, then the per-state fetch flow.
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      slot_valid_n = slot_valid;
      slot_pc_n    = slot_pc;
      slot_instr_n = slot_instr;
      skid_valid_n = skid_valid;
      skid_pc_n    = skid_pc;
      skid_instr_n = skid_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      slot_misalign_n = slot_misalign;
      misalign_done_n = misalign_done;
`endif

      if (!fetch_stall) begin
         slot_valid_n = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
         slot_misalign_n = 1'b0;
`endif
      end

      if (redirect_valid) begin
         slot_valid_n = 1'b0;
         skid_valid_n = 1'b0;
         pc_n         = redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
         slot_misalign_n = 1'b0;
         misalign_done_n = 1'b0;
`endif
         if (((state == ST_WAIT) && !imem_resp_valid) ||
             ((state == ST_DROP) && !imem_resp_valid) ||
             ((state == ST_REQ) && handshake)) begin
            state_n = ST_DROP;
         end else begin
            state_n = ST_REQ;
         end
      end else begin
         case (state)
            ST_REQ: begin
               if (handshake) begin
                  state_n = ST_WAIT;
               end
`ifdef FETCH_MISALIGN_CHECK_EN
               else if (misaligned && !misalign_done && (!slot_valid || !fetch_stall)) begin
                  slot_valid_n    = 1'b1;
                  slot_pc_n       = pc;
                  slot_instr_n    = 32'h0000_0013;
                  slot_misalign_n = 1'b1;
                  misalign_done_n = 1'b1;
               end
`endif
            end
            ST_WAIT: begin
               if (imem_resp_valid) begin
                  pc_n = pc_plus4;
                  if (!slot_valid || !fetch_stall) begin
                     slot_valid_n = 1'b1;
                     slot_pc_n    = pc;
                     slot_instr_n = imem_resp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
                     slot_misalign_n = 1'b0;
`endif
                     state_n      = ST_REQ;
                  end else begin
                     skid_valid_n = 1'b1;
                     skid_pc_n    = pc;
                     skid_instr_n = imem_resp_data;
                     state_n      = ST_FULL;
                  end
               end
            end
            ST_FULL: begin
               if (!fetch_stall) begin
                  slot_valid_n = skid_valid;
                  slot_pc_n    = skid_pc;
                  slot_instr_n = skid_instr;
                  skid_valid_n = 1'b0;
                  state_n      = ST_REQ;
               end
            end
            ST_DROP: begin
               if (imem_resp_valid) begin
                  state_n = ST_REQ;
               end
            end
            default: begin
               state_n = ST_REQ;
            end
         endcase
      end
   end

   // State, PC and buffer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_REQ;
         pc         <= RESET_PC;
         slot_valid <= 1'b0;
         slot_pc    <= 64'd0;
         slot_instr <= 32'd0;
         skid_valid <= 1'b0;
         skid_pc    <= 64'd0;
         skid_instr <= 32'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
         slot_misalign <= 1'b0;
         misalign_done <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         slot_valid <= slot_valid_n;
         slot_pc    <= slot_pc_n;
         slot_instr <= slot_instr_n;
         skid_valid <= skid_valid_n;
         skid_pc    <= skid_pc_n;
         skid_instr <= skid_instr_n;
`ifdef FETCH_MISALIGN_CHECK_EN
         slot_misalign <= slot_misalign_n;
         misalign_done <= misalign_done_n;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// Stimulus pushes expected requests and presented instructions into queues.
// A memory model and an output monitor pop and compare them independently.
module tb_fetch_unit;

   logic         clk = 1'b0;
   logic         rst;
   logic         imem_req_valid;
   logic [63:0]  imem_req_addr;
   logic         imem_req_ready;
   logic         imem_resp_valid;
   logic [31:0]  imem_resp_data;
   logic         redirect_valid;
   logic [63:0]  redirect_pc;
   logic         fetch_stall;
   logic         fetch_o_valid;
   logic [63:0]  fetch_o_pc;
   logic [31:0]  fetch_o_instr;
   logic [160:0] fetch_o_commit_info;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic         fetch_o_misalign;
`endif

   typedef struct {
      logic [63:0] pc;
      logic [63:0] next_pc;
      logic [31:0] instr;
      logic        mis;
   } out_t;

   out_t        out_q[$];
   logic [63:0] req_q[$];
   out_t        mon_e;
   int          grants_left = 0;
   int          resp_delay = 1;
   int          total = 0;
   int          bad = 0;

   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   assign imem_req_ready = (grants_left > 0);

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk                 (clk),
      .rst                 (rst),
      .imem_req_valid      (imem_req_valid),
      .imem_req_addr       (imem_req_addr),
      .imem_req_ready      (imem_req_ready),
      .imem_resp_valid     (imem_resp_valid),
      .imem_resp_data      (imem_resp_data),
      .redirect_valid      (redirect_valid),
      .redirect_pc         (redirect_pc),
      .fetch_stall         (fetch_stall),
      .fetch_o_valid       (fetch_o_valid),
      .fetch_o_pc          (fetch_o_pc),
      .fetch_o_instr       (fetch_o_instr),
`ifdef FETCH_MISALIGN_CHECK_EN
      .fetch_o_misalign    (fetch_o_misalign),
`endif
      .fetch_o_commit_info (fetch_o_commit_info)
   );

   function automatic void check_output(input string name, input logic [160:0] act, input logic [160:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'h0000_0000_8000_0000: mem_word = 32'h0010_0093;
         64'h0000_0000_8000_0004: mem_word = 32'h0020_0113;
         64'h0000_0000_8000_0008: mem_word = 32'h0030_0193;
         64'h0000_0000_8000_0100: mem_word = 32'h0040_0213;
         64'h0000_0000_8000_0300: mem_word = 32'h0050_0293;
         64'hFFFF_FFFF_FFFF_FFFC: mem_word = 32'h0060_0313;
         64'h0000_0000_0000_0000: mem_word = 32'h0070_0393;
         default:                 mem_word = 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic expect_out(input logic [63:0] pc, input logic [63:0] next_pc, input logic [31:0] instr, input logic mis);
      out_t e;
      e.pc      = pc;
      e.next_pc = next_pc;
      e.instr   = instr;
      e.mis     = mis;
      out_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model: checks each accepted request address and answers after resp_delay cycles.
   initial begin : mem_model
      logic [63:0] a;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && imem_req_valid === 1'b1 && imem_req_ready) begin
            a = imem_req_addr;
            if (req_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_req: got addr %0h expected no request", a);
            end else begin
               check_output("req_addr", 161'(a), 161'(req_q.pop_front()));
            end
            step();
            grants_left--;
            for (int k = 1; k < resp_delay; k++) begin
               step();
            end
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(a);
            step();
            imem_resp_valid = 1'b0;
         end
      end
   end

   // Output monitor: compares each instruction when downstream takes it.
   always @(negedge clk) begin
      if (rst === 1'b1 && fetch_o_valid === 1'b1 && fetch_stall === 1'b0 && redirect_valid === 1'b0) begin
         if (out_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_out: got pc %0h expected no instruction", fetch_o_pc);
         end else begin
            mon_e = out_q.pop_front();
            check_output("out_pc", 161'(fetch_o_pc), 161'(mon_e.pc));
            check_output("out_instr", 161'(fetch_o_instr), 161'(mon_e.instr));
            check_output("out_commit", fetch_o_commit_info, {1'b1, mon_e.pc, mon_e.next_pc, mon_e.instr});
`ifdef FETCH_MISALIGN_CHECK_EN
            check_output("out_misalign", 161'(fetch_o_misalign), 161'(mon_e.mis));
`endif
         end
      end else if (rst === 1'b1 && fetch_o_valid === 1'b0) begin
         check_output("idle_commit_zero", fetch_o_commit_info, 161'd0);
      end
   end

   // Reset outputs, used right after a reset edge and while rst is still low.
   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_req_valid"}, 161'(imem_req_valid), 161'(1'b0));
      check_output({tag, "_req_addr"}, 161'(imem_req_addr), 161'(RST_PC));
      check_output({tag, "_o_valid"}, 161'(fetch_o_valid), 161'(1'b0));
      check_output({tag, "_o_pc"}, 161'(fetch_o_pc), 161'd0);
      check_output({tag, "_o_instr"}, 161'(fetch_o_instr), 161'd0);
      check_output({tag, "_commit"}, fetch_o_commit_info, 161'd0);
   endtask

   task automatic apply_stimulus_reset();
      step();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'd0;
      grants_left    = 0;
      repeat (2) step();
      check_reset_outputs("reset");
   endtask

   task automatic wait_drained(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (out_q.size() == 0 && req_q.size() == 0 && imem_resp_valid === 1'b0) break;
         step();
      end
      check_output("drain_queues", 161'(out_q.size() + req_q.size()), 161'd0);
      grants_left = 0;
      repeat (2) step();
   endtask

   initial begin
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'd0;
      fetch_stall    = 1'b0;

      // Single fetch after reset release.
      apply_stimulus_reset();
      resp_delay = 1;
      req_q.push_back(64'h0000_0000_8000_0000);
      expect_out(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0004, 32'h0010_0093, 1'b0);
      grants_left = 1;
      rst = 1'b1;
      repeat (2) step();
      check_output("t1_next_req_valid", 161'(imem_req_valid), 161'(1'b1));
      check_output("t1_next_req_addr", 161'(imem_req_addr), 161'(64'h0000_0000_8000_0004));
      wait_drained(20);

      // Stall with two responses: A held, B in skid, no third request.
      apply_stimulus_reset();
      fetch_stall = 1'b1;
      req_q.push_back(64'h0000_0000_8000_0000);
      req_q.push_back(64'h0000_0000_8000_0004);
      expect_out(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0004, 32'h0010_0093, 1'b0);
      expect_out(64'h0000_0000_8000_0004, 64'h0000_0000_8000_0008, 32'h0020_0113, 1'b0);
      grants_left = 2;
      rst = 1'b1;
      repeat (4) step();
      for (int i = 0; i < 3; i++) begin
         check_output("t2_full_no_req", 161'(imem_req_valid), 161'(1'b0));
         check_output("t2_held_valid", 161'(fetch_o_valid), 161'(1'b1));
         check_output("t2_held_pc", 161'(fetch_o_pc), 161'(64'h0000_0000_8000_0000));
         check_output("t2_held_instr", 161'(fetch_o_instr), 161'(32'h0010_0093));
         step();
      end
      fetch_stall = 1'b0;
      step();
      check_output("t2_skid_pc", 161'(fetch_o_pc), 161'(64'h0000_0000_8000_0004));
      check_output("t2_after_req_valid", 161'(imem_req_valid), 161'(1'b1));
      check_output("t2_after_req_addr", 161'(imem_req_addr), 161'(64'h0000_0000_8000_0008));
      wait_drained(20);

      // Redirect while waiting on a slow response; slot held under stall is flushed.
      apply_stimulus_reset();
      fetch_stall = 1'b1;
      resp_delay  = 3;
      req_q.push_back(64'h0000_0000_8000_0000);
      req_q.push_back(64'h0000_0000_8000_0004);
      req_q.push_back(64'h0000_0000_8000_0100);
      expect_out(64'h0000_0000_8000_0100, 64'h0000_0000_8000_0104, 32'h0040_0213, 1'b0);
      grants_left = 3;
      rst = 1'b1;
      repeat (5) step();
      check_output("t3_pre_valid", 161'(fetch_o_valid), 161'(1'b1));
      check_output("t3_pre_pc", 161'(fetch_o_pc), 161'(64'h0000_0000_8000_0000));
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0000_0000_8000_0100;
      step();
      redirect_valid = 1'b0;
      fetch_stall    = 1'b0;
      check_output("t3_flush_valid", 161'(fetch_o_valid), 161'(1'b0));
      check_output("t3_flush_commit", fetch_o_commit_info, 161'd0);
      check_output("t3_drop_no_req", 161'(imem_req_valid), 161'(1'b0));
      wait_drained(40);

      // Redirect coinciding with the discarded response in DROP.
      apply_stimulus_reset();
      resp_delay = 3;
      req_q.push_back(64'h0000_0000_8000_0000);
      req_q.push_back(64'h0000_0000_8000_0300);
      expect_out(64'h0000_0000_8000_0300, 64'h0000_0000_8000_0304, 32'h0050_0293, 1'b0);
      grants_left = 2;
      rst = 1'b1;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0000_0000_8000_0200;
      step();
      redirect_valid = 1'b0;
      check_output("t4_drop_no_req", 161'(imem_req_valid), 161'(1'b0));
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0000_0000_8000_0300;
      step();
      redirect_valid = 1'b0;
      check_output("t4_req_valid", 161'(imem_req_valid), 161'(1'b1));
      check_output("t4_req_addr", 161'(imem_req_addr), 161'(64'h0000_0000_8000_0300));
      check_output("t4_slot_empty", 161'(fetch_o_valid), 161'(1'b0));
      wait_drained(40);

      // Reset asserted in WAIT while the response arrives.
      apply_stimulus_reset();
      resp_delay = 1;
      req_q.push_back(64'h0000_0000_8000_0000);
      grants_left = 1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check_reset_outputs("t5");
      req_q.push_back(64'h0000_0000_8000_0000);
      expect_out(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0004, 32'h0010_0093, 1'b0);
      grants_left = 1;
      rst = 1'b1;
      #1;
      check_output("t5_rereq_valid", 161'(imem_req_valid), 161'(1'b1));
      check_output("t5_rereq_addr", 161'(imem_req_addr), 161'(RST_PC));
      wait_drained(20);

      // PC wrap from the top of the address space.
      apply_stimulus_reset();
      resp_delay     = 1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      rst = 1'b1;
      step();
      redirect_valid = 1'b0;
      check_output("t6_req_addr", 161'(imem_req_addr), 161'(64'hFFFF_FFFF_FFFF_FFFC));
      req_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      req_q.push_back(64'h0000_0000_0000_0000);
      expect_out(64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000, 32'h0060_0313, 1'b0);
      expect_out(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0004, 32'h0070_0393, 1'b0);
      grants_left = 2;
      wait_drained(30);

      // Misaligned redirect target.
      apply_stimulus_reset();
      resp_delay     = 1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0000_0000_8000_0102;
      rst = 1'b1;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      check_output("t7_no_req", 161'(imem_req_valid), 161'(1'b0));
      expect_out(64'h0000_0000_8000_0102, 64'h0000_0000_8000_0106, 32'h0000_0013, 1'b1);
      grants_left = 1;
      wait_drained(20);
      grants_left = 1;
      repeat (3) begin
         check_output("t7_idle_no_req", 161'(imem_req_valid), 161'(1'b0));
         check_output("t7_idle_empty", 161'(fetch_o_valid), 161'(1'b0));
         step();
      end
      grants_left = 0;
`else
      check_output("t7_aligned_addr", 161'(imem_req_addr), 161'(64'h0000_0000_8000_0100));
      req_q.push_back(64'h0000_0000_8000_0100);
      expect_out(64'h0000_0000_8000_0102, 64'h0000_0000_8000_0106, 32'h0040_0213, 1'b0);
      grants_left = 1;
      wait_drained(20);
      check_output("t7_next_addr", 161'(imem_req_addr), 161'(64'h0000_0000_8000_0104));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
